// File: rtl/fxp_q2_14_mult_pkg.sv
// Shared widths, saturation limits and width-consistency check for the
// signed fixed-point multiplier.
package fxp_mult_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int FRAC_WIDTH = 14;
  localparam int INT_WIDTH  = 2;
  localparam int DFRAC      = 28;
  localparam int DINT       = 4;
  localparam int DWIDTH     = 32;

  function automatic longint sat_max(int dw);
    return (longint'(1) <<< (dw - 1)) - 1;
  endfunction

  function automatic longint sat_min(int dw);
    return -(longint'(1) <<< (dw - 1));
  endfunction

  function automatic longint round_half(int fw);
    return longint'(1) <<< (fw - 1);
  endfunction

  localparam logic [DATA_WIDTH-1:0] SAT_MAX    = DATA_WIDTH'(sat_max(DATA_WIDTH));
  localparam logic [DATA_WIDTH-1:0] SAT_MIN    = DATA_WIDTH'(sat_min(DATA_WIDTH));
  localparam logic [DWIDTH-1:0]     ROUND_HALF = DWIDTH'(round_half(FRAC_WIDTH));

  function automatic bit widths_ok(int dw, int fw, int iw, int df, int di, int dwd);
    return (iw + fw == dw) && (df == 2 * fw) && (di == 2 * iw) &&
           (dwd == 2 * dw) && (dwd == di + df);
  endfunction

endpackage

// File: rtl/fxp_q2_14_mult_if.sv
// Operand/result bundle of the multiplier. Free-running: no valid/ready,
// every clock edge samples A_in/B_in and advances the pipeline by one stage.
interface fxp_q2_14_mult_if #(
  parameter int data_width = 16
);
  logic [data_width-1:0] A_in;
  logic [data_width-1:0] B_in;
  logic [data_width-1:0] out;
  logic                  overflow_flag;
  logic                  underflow_flag;

  modport master (output A_in, output B_in,
                  input  out, input overflow_flag, input underflow_flag);
  modport slave  (input  A_in, input B_in,
                  output out, output overflow_flag, output underflow_flag);
endinterface

// File: rtl/fxp_round_sat.sv
// Combinational round-to-nearest (ties toward +inf) and saturate of a
// full-precision product back to the operand format.
module fxp_round_sat
  import fxp_mult_pkg::*;
#(
  parameter int data_width = DATA_WIDTH,
  parameter int frac_width = FRAC_WIDTH,
  parameter int dwidth     = DWIDTH
) (
  input  logic signed [dwidth-1:0]     p_i,
  output logic        [data_width-1:0] res_o,
  output logic                         ovf_o,
  output logic                         unf_o
);

  // One guard bit above the product so adding the half-LSB cannot wrap.
  localparam logic signed [dwidth:0] HALF_V = (dwidth+1)'(round_half(frac_width));
  localparam logic signed [dwidth:0] MAX_V  = (dwidth+1)'(sat_max(data_width));
  localparam logic signed [dwidth:0] MIN_V  = (dwidth+1)'(sat_min(data_width));

  logic signed [dwidth:0] p_ext;
  logic signed [dwidth:0] sum;
  logic signed [dwidth:0] r;

  assign p_ext = {p_i[dwidth-1], p_i};
  assign sum   = p_ext + HALF_V;
  assign r     = sum >>> frac_width;

  always_comb begin
    res_o = r[data_width-1:0];
    ovf_o = 1'b0;
    unf_o = 1'b0;
    if (r > MAX_V) begin
      res_o = MAX_V[data_width-1:0];
      ovf_o = 1'b1;
    end else if (r < MIN_V) begin
      res_o = MIN_V[data_width-1:0];
      unf_o = 1'b1;
    end
  end

endmodule

// File: rtl/fxp_q2_14_mult.sv
// Two-stage signed fixed-point multiplier: registered full product, then
// registered round/saturate result with per-sample overflow/underflow flags.
module fxp_q2_14_mult
  import fxp_mult_pkg::*;
#(
  parameter int data_width = DATA_WIDTH,
  parameter int frac_width = FRAC_WIDTH,
  parameter int int_width  = INT_WIDTH,
  parameter int dfrac      = DFRAC,
  parameter int dint       = DINT,
  parameter int dwidth     = DWIDTH
) (
  input  logic               clk,
  input  logic               reset,
  fxp_q2_14_mult_if.slave    bus
);

  if (!widths_ok(data_width, frac_width, int_width, dfrac, dint, dwidth)) begin : g_bad_widths
    $error("fxp_q2_14_mult: inconsistent width parameters");
  end

  logic signed [data_width-1:0] a_s;
  logic signed [data_width-1:0] b_s;
  logic signed [dwidth-1:0]     prod_d, prod_q;
  logic        [data_width-1:0] out_d, out_q;
  logic                         ovf_d, ovf_q;
  logic                         unf_d, unf_q;

  assign a_s    = bus.A_in;
  assign b_s    = bus.B_in;
  // Sign-extend before multiplying so the product is exact at full width.
  assign prod_d = dwidth'(a_s) * dwidth'(b_s);

  fxp_round_sat #(
    .data_width (data_width),
    .frac_width (frac_width),
    .dwidth     (dwidth)
  ) u_round_sat (
    .p_i   (prod_q),
    .res_o (out_d),
    .ovf_o (ovf_d),
    .unf_o (unf_d)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prod_q <= '0;
      out_q  <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      prod_q <= prod_d;
      out_q  <= out_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  assign bus.out            = out_q;
  assign bus.overflow_flag  = ovf_q;
  assign bus.underflow_flag = unf_q;

endmodule

// File: tb/tb_fxp_q2_14_mult.sv
// Directed-vector bench for the Q2.14 multiplier: reset, nominal, rounding,
// saturation, streaming and asynchronous mid-stream reset.
module tb_fxp_q2_14_mult;
  import fxp_mult_pkg::*;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;

  fxp_q2_14_mult_if #(.data_width(16)) bus ();

  fxp_q2_14_mult dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [15:0] a, input logic [15:0] b);
    bus.A_in = a;
    bus.B_in = b;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
      @(negedge clk);
      n_cmp++;
      if (bus.out !== 16'h0000 || bus.overflow_flag !== 1'b0 || bus.underflow_flag !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold cyc%0d: out=%h ovf=%b unf=%b, required out=0000 ovf=0 unf=0",
                 i, bus.out, bus.overflow_flag, bus.underflow_flag);
      end
    end
    // Release with a live sample present; it must take two edges to show.
    reset = 1'b1;
    drive(16'h4000, 16'h4000);
    @(negedge clk);
    drive(16'h0000, 16'h0000);
    n_cmp++;
    if (bus.out !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_release_early: out=%h, required 0000", bus.out);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.out !== 16'h4000 || bus.overflow_flag !== 1'b0 || bus.underflow_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_first_sample: out=%h ovf=%b unf=%b, required out=4000 ovf=0 unf=0",
               bus.out, bus.overflow_flag, bus.underflow_flag);
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  // Isolated vectors separated by zero samples so exact latency is observable.
  task automatic test_vectors(input string name, input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] exp, input logic e_ovf, input logic e_unf);
    drive(a, b);
    @(negedge clk);
    drive(16'h0000, 16'h0000);
    n_cmp++;
    if (bus.out !== 16'h0000 || bus.overflow_flag !== 1'b0 || bus.underflow_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_latency: out=%h ovf=%b unf=%b one cycle early, required 0000/0/0",
               name, bus.out, bus.overflow_flag, bus.underflow_flag);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.out !== exp || bus.overflow_flag !== e_ovf || bus.underflow_flag !== e_unf) begin
      n_fail++;
      $display("FAIL %s: %h*%h out=%h ovf=%b unf=%b, required out=%h ovf=%b unf=%b",
               name, a, b, bus.out, bus.overflow_flag, bus.underflow_flag, exp, e_ovf, e_unf);
    end
    @(negedge clk);
  endtask

  task automatic test_nominal();
    test_vectors("nom_1x1",    16'h4000, 16'h4000, 16'h4000, 1'b0, 1'b0);
    test_vectors("nom_m15x1",  16'hA000, 16'h4000, 16'hA000, 1'b0, 1'b0);
    test_vectors("nom_max_x",  16'h7FFF, 16'h0020, 16'h0040, 1'b0, 1'b0);
  endtask

  task automatic test_rounding();
    test_vectors("rnd_small",  16'h0020, 16'h0010, 16'h0000, 1'b0, 1'b0);
    test_vectors("rnd_tie_p",  16'h0001, 16'h2000, 16'h0001, 1'b0, 1'b0);
    test_vectors("rnd_tie_n",  16'hFFFF, 16'h2000, 16'h0000, 1'b0, 1'b0);
    test_vectors("rnd_m1m1",   16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
    test_vectors("rnd_minm1",  16'h8000, 16'hFFFF, 16'h0002, 1'b0, 1'b0);
  endtask

  task automatic test_saturation();
    test_vectors("sat_pos_max", 16'h7FFF, 16'h7FFF, SAT_MAX, 1'b1, 1'b0);
    test_vectors("sat_pos_min", 16'h8000, 16'h8000, SAT_MAX, 1'b1, 1'b0);
    test_vectors("sat_neg_a",   16'h7FFF, 16'h8000, SAT_MIN, 1'b0, 1'b1);
    test_vectors("sat_neg_b",   16'h8000, 16'h7FFF, SAT_MIN, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [15:0] va [8] = '{16'h2000, 16'h6000, 16'h1000, 16'h6000, 16'hC000, 16'h7FFF, 16'hC000, 16'h0001};
    logic [15:0] vb [8] = '{16'h2000, 16'h6000, 16'h1000, 16'hA000, 16'h4000, 16'h7FFF, 16'h6000, 16'h2000};
    logic [15:0] ve [8] = '{16'h1000, 16'h7FFF, 16'h0400, 16'h8000, 16'hC000, 16'h7FFF, 16'hA000, 16'h0001};
    logic        vo [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        vu [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (i >= 2) begin
        n_cmp++;
        if (bus.out !== ve[i-2] || bus.overflow_flag !== vo[i-2] || bus.underflow_flag !== vu[i-2]) begin
          n_fail++;
          $display("FAIL stream%0d: out=%h ovf=%b unf=%b, required out=%h ovf=%b unf=%b",
                   i - 2, bus.out, bus.overflow_flag, bus.underflow_flag, ve[i-2], vo[i-2], vu[i-2]);
        end
      end
      if (i < 8) drive(va[i], vb[i]);
      else       drive(16'h0000, 16'h0000);
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    drive(16'h7FFF, 16'h7FFF);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.out !== 16'h7FFF || bus.overflow_flag !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_pre: out=%h ovf=%b, required out=7fff ovf=1", bus.out, bus.overflow_flag);
    end
    // Stage 1 still holds an overflowing sample when reset hits.
    #2;
    reset = 1'b0;
    drive(16'h0000, 16'h0000);
    #1;
    n_cmp++;
    if (bus.out !== 16'h0000 || bus.overflow_flag !== 1'b0 || bus.underflow_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_immediate: out=%h ovf=%b unf=%b, required 0000/0/0",
               bus.out, bus.overflow_flag, bus.underflow_flag);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.out !== 16'h0000 || bus.overflow_flag !== 1'b0 || bus.underflow_flag !== 1'b0) begin
        n_fail++;
        $display("FAIL areset_flush%0d: out=%h ovf=%b unf=%b, required 0000/0/0",
                 i, bus.out, bus.overflow_flag, bus.underflow_flag);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_cmp  = 0;
    n_fail = 0;
    reset  = 1'b0;
    drive(16'h0000, 16'h0000);
    @(negedge clk);
    test_reset();
    test_nominal();
    test_rounding();
    test_saturation();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
